// File: rtl/fetch_pc_ctrl.sv
// Fetch PC controller: owns the PC, issues single-outstanding imem reads and fills the IF/DEC register.
// Optional FETCH_MISALIGN_TRAP_EN adds a sticky misalign output that parks fetch on a misaligned redirect.
module fetch_pc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clock,
  input  logic        nReset,
  input  logic        flush,
  input  logic        hold,
  input  logic        branch,
  input  logic        bypass,
  input  logic [31:0] PCnext,
  input  logic [31:0] PCcurrent,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PCIF,
  output logic [31:0] instrIF,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic        misalign,
`endif
  output logic        validIF
);

  localparam logic [2:0] BOOT = 3'd0;
  localparam logic [2:0] REQ  = 3'd1;
  localparam logic [2:0] RESP = 3'd2;
  localparam logic [2:0] SKID = 3'd3;
  localparam logic [2:0] DROP = 3'd4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [2:0]  state, stateNext;
  logic [31:0] pc, skidPc, skidData;
  logic        skidValid;
  logic        redirect, trapped;
  logic [31:0] rawTarget, target;
  logic        respTaken, loadResp, toSkid, loadSkid, loadEn;
  logic [31:0] loadPc, loadInstr;

  assign redirect  = branch | bypass;
  assign rawTarget = bypass ? PCnext : (PCcurrent + PCnext);
  assign target    = rawTarget & ~32'h3;

  assign imem_req  = (state == REQ);
  assign imem_addr = pc;

  // In RESP the pc still equals the address of the outstanding read
  assign respTaken = (state == RESP) && imem_rvalid && !redirect;
  assign loadResp  = respTaken && !hold;
  assign toSkid    = respTaken && hold;
  assign loadSkid  = (state == SKID) && skidValid && !redirect && !hold;
  assign loadEn    = loadResp | loadSkid;
  assign loadPc    = loadSkid ? skidPc : pc;
  assign loadInstr = loadSkid ? skidData : imem_rdata;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic trapNow;
  assign trapNow = redirect && (rawTarget[1:0] != 2'b00);
  assign trapped = trapNow | misalign;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset)      misalign <= 1'b0;
    else if (trapNow) misalign <= 1'b1;
  end
`else
  assign trapped = 1'b0;
`endif

  always_comb begin
    stateNext = state;
    case (state)
      BOOT: stateNext = REQ;
      REQ:  if (imem_gnt) stateNext = redirect ? DROP : RESP;
      RESP: begin
        if (imem_rvalid)   stateNext = (redirect || !hold) ? REQ : SKID;
        else if (redirect) stateNext = DROP;
      end
      SKID: if (redirect || !hold) stateNext = REQ;
      DROP: if (imem_rvalid) stateNext = REQ;
      default: stateNext = BOOT;
    endcase
    if (trapped) stateNext = BOOT;
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) state <= BOOT;
    else         state <= stateNext;
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset)        pc <= RESET_PC;
    else if (redirect)  pc <= target;
    else if (respTaken) pc <= pc + 32'd4;
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      skidValid <= 1'b0;
      skidPc    <= '0;
      skidData  <= NOP;
    end else if (redirect || loadSkid) begin
      skidValid <= 1'b0;
    end else if (toSkid) begin
      skidValid <= 1'b1;
      skidPc    <= pc;
      skidData  <= imem_rdata;
    end
  end

  // A held entry stays visible to decode; otherwise it is a one-cycle pulse
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      PCIF    <= '0;
      instrIF <= NOP;
      validIF <= 1'b0;
    end else if (redirect || trapped) begin
      instrIF <= NOP;
      validIF <= 1'b0;
    end else if (loadEn) begin
      PCIF    <= loadPc;
      instrIF <= loadInstr;
      validIF <= 1'b1;
    end else if (flush || !hold) begin
      validIF <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Randomized bench for fetch_pc_ctrl against a transaction-level fetch model (one outstanding read,
// skid queue, discard flag) with a latency-randomized instruction memory.
module tb_fetch_pc_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        Clock = 1'b0;
  logic        nReset = 1'b0;
  logic        flush = 1'b0, hold = 1'b0, branch = 1'b0, bypass = 1'b0;
  logic [31:0] PCnext = '0, PCcurrent = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] PCIF, instrIF;
  logic        validIF;

  int assertCount = 0;
  int failCount = 0;

  // Reference model state
  logic [31:0] mPc, mPCIF, mInstr;
  logic        mValid, mBoot, mOut, mDiscard;
  logic [63:0] skidQ[$];

  // Memory model and stimulus knobs
  logic        memPending = 1'b0;
  logic [31:0] memAddr = '0;
  int          memWait = 0;
  int          gntPct = 100, minLat = 1, maxLat = 1;
  logic        forceRv = 1'b0;

  fetch_pc_ctrl #(.RESET_PC(RST_PC)) dut (
    .Clock(Clock), .nReset(nReset), .flush(flush), .hold(hold), .branch(branch), .bypass(bypass),
    .PCnext(PCnext), .PCcurrent(PCcurrent), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .PCIF(PCIF), .instrIF(instrIF), .validIF(validIF)
  );

  always #5 Clock = ~Clock;

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    return {addr[29:0], 2'b11} ^ 32'hA55A_0000;
  endfunction

  function automatic logic mReq();
    return !mBoot && !mOut && (skidQ.size() == 0);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s at %0t: observed %h expected %h", tag, $time, observed, expected);
    end
  endtask

  task automatic checkAll();
    checkOutput("imem_req", {31'd0, imem_req}, {31'd0, mReq()});
    checkOutput("imem_addr", imem_addr, mPc);
    checkOutput("PCIF", PCIF, mPCIF);
    checkOutput("instrIF", instrIF, mInstr);
    checkOutput("validIF", {31'd0, validIF}, {31'd0, mValid});
  endtask

  task automatic modelReset();
    mPc = RST_PC; mBoot = 1'b1; mOut = 1'b0; mDiscard = 1'b0;
    skidQ.delete();
    mPCIF = '0; mInstr = NOP; mValid = 1'b0;
    memPending = 1'b0;
  endtask

  // One clock of fetch behaviour, from the rules for redirect, hold, flush and the single read slot
  task automatic modelUpdate(input logic h, f, br, bp, g, rv, input logic [31:0] pn, pcur, rd);
    logic redir, load, hadSkid, reqNow;
    logic [31:0] tgt, lpc, ldata;
    redir = br | bp;
    tgt = (bp ? pn : pcur + pn) & ~32'h3;
    load = 1'b0; lpc = '0; ldata = '0;
    hadSkid = (skidQ.size() != 0);
    reqNow = mReq();
    if (mBoot) mBoot = 1'b0;
    else if (reqNow && g) begin
      mOut = 1'b1;
      mDiscard = redir;
    end else if (mOut && rv) begin
      if (!mDiscard && !redir) begin
        if (h) skidQ.push_back({mPc, rd});
        else begin load = 1'b1; lpc = mPc; ldata = rd; end
        mPc = mPc + 32'd4;
      end
      mOut = 1'b0;
      mDiscard = 1'b0;
    end else if (mOut && redir) mDiscard = 1'b1;
    if (hadSkid) begin
      if (redir) skidQ.delete();
      else if (!h) begin {lpc, ldata} = skidQ.pop_front(); load = 1'b1; end
    end
    if (redir) mPc = tgt;
    if (redir) begin mValid = 1'b0; mInstr = NOP; end
    else if (load) begin mPCIF = lpc; mInstr = ldata; mValid = 1'b1; end
    else if (f || !h) mValid = 1'b0;
  endtask

  task automatic applyStimulus(input logic h, f, br, bp, input logic [31:0] pn, pcur);
    logic [31:0] addrBefore;
    logic gntNow, rvNow;
    @(negedge Clock);
    checkAll();
    hold = h; flush = f; branch = br; bypass = bp; PCnext = pn; PCcurrent = pcur;
    imem_gnt = mReq() && ($urandom_range(99) < gntPct);
    imem_rvalid = forceRv | (memPending && memWait == 0);
    imem_rdata = (memPending && memWait == 0) ? memWord(memAddr) : $urandom;
    @(posedge Clock);
    addrBefore = mPc;
    gntNow = imem_gnt;
    rvNow = imem_rvalid;
    modelUpdate(h, f, br, bp, gntNow, rvNow, pn, pcur, imem_rdata);
    if (rvNow && memPending) memPending = 1'b0;
    else if (memPending && memWait > 0) memWait--;
    if (gntNow) begin
      memPending = 1'b1;
      memAddr = addrBefore;
      memWait = $urandom_range(maxLat - 1, minLat - 1);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic doReset();
    @(negedge Clock);
    nReset = 1'b0;
    hold = 0; flush = 0; branch = 0; bypass = 0; imem_gnt = 0; imem_rvalid = 0;
    #1;
    modelReset();
    checkAll();
    checkOutput("rstInstr", instrIF, 32'h0000_0013);
    repeat (2) @(posedge Clock);
    #2 nReset = 1'b1;
  endtask

  initial begin
    doReset();

    // Zero-wait memory: 100, 104, 108 with one instruction every two cycles
    gntPct = 100; minLat = 1; maxLat = 1;
    idle(3);
    #1;
    checkOutput("seqAddr104", imem_addr, 32'h104);
    checkOutput("seqPCIF100", PCIF, 32'h100);
    checkOutput("seqValid", {31'd0, validIF}, 32'd1);
    idle(2);
    #1;
    checkOutput("seqAddr108", imem_addr, 32'h108);

    // Bypass while waiting for a slow response: stale word must be dropped
    minLat = 3; maxLat = 3;
    idle(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h2003, '0);
    idle(2);
    #1;
    checkOutput("dropAddr", imem_addr, 32'h2000);
    checkOutput("dropReq", {31'd0, imem_req}, 32'd1);
    checkOutput("dropValid", {31'd0, validIF}, 32'd0);

    // Relative branch with negative offset while the request waits for a grant
    minLat = 1; maxLat = 1; gntPct = 0;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFF0, 32'h40);
    #1;
    checkOutput("brAddr", imem_addr, 32'h30);
    checkOutput("brValid", {31'd0, validIF}, 32'd0);

    // Response arrives during a three-cycle hold and waits in the skid
    gntPct = 100;
    idle(1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    #1;
    checkOutput("holdNoReq", {31'd0, imem_req}, 32'd0);
    idle(1);
    #1;
    checkOutput("skidPCIF", PCIF, 32'h30);
    checkOutput("skidValid", {31'd0, validIF}, 32'd1);
    checkOutput("skidNextAddr", imem_addr, 32'h34);

    // Flush alone, then simultaneous bypass and branch
    gntPct = 0;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
    #1;
    checkOutput("flushValid", {31'd0, validIF}, 32'd0);
    checkOutput("flushPc", imem_addr, 32'h34);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'h5000, 32'h100);
    #1;
    checkOutput("bpWins", imem_addr, 32'h5000);

    // Reset during a pending response; a late rvalid must be ignored
    gntPct = 100; minLat = 3; maxLat = 3;
    idle(2);
    doReset();
    forceRv = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    forceRv = 1'b0;
    #1;
    checkOutput("rstFirstAddr", imem_addr, RST_PC);
    checkOutput("rstNoValid", {31'd0, validIF}, 32'd0);

    // Randomized traffic, including targets near the top of memory for pc wrap
    gntPct = 60; minLat = 1; maxLat = 4;
    for (int i = 0; i < 3000; i++) begin
      logic h, f, br, bp;
      logic [31:0] pn, pcur;
      h = ($urandom_range(99) < 20);
      f = ($urandom_range(99) < 10);
      br = ($urandom_range(99) < 5);
      bp = ($urandom_range(99) < 5);
      pcur = $urandom;
      case ($urandom_range(3))
        0: pn = $urandom;
        1: pn = 32'hFFFF_FFFC;
        2: pn = {$urandom_range(255), 2'b00};
        default: pn = 32'hFFFF_FFF4 | {30'd0, 2'($urandom_range(3))};
      endcase
      applyStimulus(h, f, br, bp, pn, pcur);
    end
    idle(4);
    @(negedge Clock);
    checkAll();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
